// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves stage stall
// requests into register enable/flush pairs and sequences exception redirects.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned EXC_TARGET_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_if,
  input  logic                    stall_id,
  input  logic                    stall_ex,
  input  logic                    stall_mem,
  input  logic                    if_busy,
  input  logic                    exc_valid,
  input  logic [EXC_TARGET_W-1:0] exc_target,
  output logic [4:0]              en_o,
  output logic [4:0]              flush_o,
  output logic                    redirect_valid,
  output logic [EXC_TARGET_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        exc_count
);

  localparam int unsigned NREG = 5;
  localparam logic [NREG-1:0] EXC_FLUSH = 5'b11110;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_IF = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [EXC_TARGET_W-1:0] r_tgt;
  logic [EXC_TARGET_W-1:0] w_tgt_nxt;
  logic [CNT_W-1:0]        r_stall_cycles;
  logic [CNT_W-1:0]        r_exc_count;
  logic                    w_exc_accept;
  logic [NREG-1:0]         w_run_en;
  logic [NREG-1:0]         w_run_flush;
  logic [NREG-1:0]         w_en;
  logic [NREG-1:0]         w_flush;
  logic                    w_redirect_valid;
  logic [EXC_TARGET_W-1:0] w_redirect_pc;

  // Deepest stalling stage holds everything upstream and bubbles itself.
  always_comb begin
    w_run_en    = 5'b11111;
    w_run_flush = 5'b00000;
    if (stall_mem) begin
      w_run_en    = 5'b10000;
      w_run_flush = 5'b10000;
    end else if (stall_ex) begin
      w_run_en    = 5'b11000;
      w_run_flush = 5'b01000;
    end else if (stall_id) begin
      w_run_en    = 5'b11100;
      w_run_flush = 5'b00100;
    end else if (stall_if) begin
      w_run_en    = 5'b11110;
      w_run_flush = 5'b00010;
    end
  end

  // Next-state and output decode; exceptions override every stall request.
  always_comb begin
    w_state_nxt      = r_state;
    w_tgt_nxt        = r_tgt;
    w_exc_accept     = 1'b0;
    w_en             = w_run_en;
    w_flush          = w_run_flush;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    if (rst) begin
      w_state_nxt = RUN;
      w_tgt_nxt   = '0;
      w_en        = '0;
      w_flush     = 5'b11111;
    end else begin
      case (r_state)
        RUN: begin
          if (exc_valid) begin
            w_exc_accept = 1'b1;
            w_flush      = EXC_FLUSH;
            if (if_busy) begin
              w_en        = '0;
              w_tgt_nxt   = exc_target;
              w_state_nxt = WAIT_IF;
            end else begin
              w_en             = 5'b00001;
              w_redirect_valid = 1'b1;
              w_redirect_pc    = exc_target;
            end
          end
        end
        WAIT_IF: begin
          w_flush = EXC_FLUSH;
          if (exc_valid) begin
            w_tgt_nxt = exc_target;
          end
          if (if_busy) begin
            w_en = '0;
          end else begin
            w_en             = 5'b00001;
            w_redirect_valid = 1'b1;
            w_redirect_pc    = r_tgt;
            w_state_nxt      = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_tgt          <= '0;
      r_stall_cycles <= '0;
      r_exc_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      if (!w_en[0] && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_exc_accept && (r_exc_count != {CNT_W{1'b1}})) begin
        r_exc_count <= r_exc_count + CNT_W'(1);
      end
    end
  end

  // An exception and an MEM stall in the same cycle indicate an upstream bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(exc_valid && stall_mem));
    end
  end

  assign en_o           = w_en;
  assign flush_o        = w_flush;
  assign redirect_valid = w_redirect_valid;
  assign redirect_pc    = w_redirect_pc;
  assign stall_cycles   = r_stall_cycles;
  assign exc_count      = r_exc_count;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Collects stall requests from the IF, ID, EX and MEM stages and the precise-exception request from MEM.
- Drives the enable/flush pair of every pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Sequences exception redirects so that an in-flight multicycle instruction fetch is never aborted mid-transaction. Also keeps saturating stall and exception performance counters.

Parameters:
- CNT_W, 32, width of the stall_cycles and exc_count counters.
- EXC_TARGET_W, 32, width of exc_target and redirect_pc.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall_if  in  1  fetch not complete this cycle
- stall_id  in  1  load-use or operand hazard in ID
- stall_ex  in  1  multicycle mult/div busy in EX
- stall_mem  in  1  data access not complete in MEM
- if_busy  in  1  instruction-fetch bus transaction outstanding (cannot be cancelled)
- exc_valid  in  1  MEM commits an exception this cycle
- exc_target  in  EXC_TARGET_W  exception handler PC
- en_o  out  5  register enables; bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB
- flush_o  out  5  register clears (load NOP); same bit order
- redirect_valid  out  1  PC loads redirect_pc this cycle
- redirect_pc  out  EXC_TARGET_W  redirect target
- stall_cycles  out  CNT_W  cycles with en_o[0]==0
- exc_count  out  CNT_W  exceptions accepted

Behaviour:
Stall resolution (RUN state, no exception), combinational, zero latency:
- Stall level s is taken by priority MEM(4) > EX(3) > ID(2) > IF(1); s=0 when no stall is asserted.
- Registers with index < s: en=0, flush=0 (hold).
- Register s: en=1, flush=1 (bubble).
- Registers with index > s: en=1, flush=0 (advance).
- s=0: en_o=5'b11111, flush_o=0.
- flush has priority over en inside each pipeline register. When both bits of a pair are 1, the register loads NOP.

FSM, two states: RUN and WAIT_IF.

RUN:
- exc_valid=1 and if_busy=0:
  - redirect_valid=1 and redirect_pc=exc_target in the same cycle.
  - en_o=5'b00001, flush_o=5'b11110.
  - Stay in RUN.
- exc_valid=1 and if_busy=1:
  - Latch exc_target into tgt_q.
  - en_o=0, flush_o=5'b11110.
  - Next state WAIT_IF.
- exc_valid overrides all stall requests, including stall_mem. A simulation assertion fires if exc_valid and stall_mem are high together.

WAIT_IF:
- While if_busy=1: en_o=0, flush_o=5'b11110, redirect_valid=0.
- First cycle with if_busy=0:
  - redirect_valid=1, redirect_pc=tgt_q.
  - en_o=5'b00001, flush_o=5'b11110.
  - Next state RUN.
- The fetched word returning in that final busy cycle is discarded, because IF/ID is flushed.
- A new exc_valid during WAIT_IF overwrites tgt_q and does not change state. It is not counted again.

Outputs and counters:
- redirect_pc is 0 whenever redirect_valid=0.
- exc_count increments by 1 on every exc_valid accepted in RUN.
- stall_cycles increments on every cycle in which en_o[0]==0.
- Both counters saturate at all-ones; they do not wrap.

Reset:
- While rst=1, outputs are forced combinationally to: en_o=0, flush_o=5'b11111, redirect_valid=0, redirect_pc=0.
- Next state is RUN; tgt_q=0; counters=0.
- rst asserted in WAIT_IF abandons the pending redirect; no redirect is issued after reset.

Test Plan:
- No stalls, no exception -> en_o=5'b11111, flush_o=5'b00000, stall_cycles stays 0.
- stall_if=1 and stall_id=1 together -> s=2: en_o=5'b11100, flush_o=5'b00100; stall_cycles +1 per cycle.
- stall_mem=1 with stall_ex=1 for 3 cycles -> en_o=5'b10000, flush_o=5'b10000 each cycle; stall_cycles=3.
- exc_valid=1, exc_target=32'hBFC00380, if_busy=0 -> same cycle redirect_valid=1, redirect_pc=32'hBFC00380, en_o=5'b00001, flush_o=5'b11110; exc_count=1.
- exc_valid=1, exc_target=32'h80000180, if_busy=1 for 3 cycles -> 3 cycles en_o=0, flush_o=5'b11110, redirect_valid=0; 4th cycle redirect_valid=1, redirect_pc=32'h80000180; then RUN with en_o=5'b11111.
- rst pulsed in 2nd WAIT_IF cycle -> no redirect afterwards, counters=0. Separately, with CNT_W=4 and stall_id held for 20 cycles -> stall_cycles=4'hF.
